sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 91 +++++++++
 tb/tb_sram_controller.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// sram_controller: MEM-stage bridge that splits each 32-bit load/store into two
// 16-bit SRAM accesses followed by a settle period, freezing the pipeline via ready.
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);
    localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, ACC_LO, ACC_HI, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic          wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   offset;
    logic          acc, hi, wr_acc;
    logic          unused_ok;

    assign offset    = address - 32'(BASE_ADDR);
    assign unused_ok = ^{offset[31:19], offset[1:0]};
    assign acc       = state_q == ACC_LO || state_q == ACC_HI;
    assign hi        = state_q == ACC_HI;
    assign wr_acc    = acc && wr_q;

    assign SRAM_ADDR = acc ? {offset[18:2], hi} : 18'd0;
    assign SRAM_WE_N = ~wr_acc;
    assign SRAM_OE_N = wr_acc;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_DQ   = wr_acc ? (hi ? writeData[31:16] : writeData[15:0]) : 16'bz;
    assign readData  = rdata_q;
    assign ready     = ~(wr_en | rd_en) | (state_q == DONE);

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        cnt_d   = '0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                wr_d    = wr_en;
                state_d = (wr_en | rd_en) ? ACC_LO : IDLE;
            end
            ACC_LO: begin
                rdata_d[15:0] = wr_q ? rdata_q[15:0] : SRAM_DQ;
                state_d       = ACC_HI;
            end
            ACC_HI: begin
                rdata_d[31:16] = wr_q ? rdata_q[31:16] : SRAM_DQ;
                state_d        = WAIT_CYCLES == 0 ? DONE : WAIT;
            end
            WAIT: begin
                // Counter runs 0..WAIT_CYCLES-1 so WAIT lasts exactly WAIT_CYCLES cycles
                cnt_d   = cnt_q == CW'(WAIT_CYCLES - 1) ? '0 : cnt_q + 1'b1;
                state_d = cnt_q == CW'(WAIT_CYCLES - 1) ? DONE : WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed accesses against a behavioural SRAM; a negedge
// monitor compares readData in DONE against a queue of expected values.
module tb_sram_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] writeData = '0;
    logic [31:0] readData;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

    logic        probe = 1'b0;
    logic [15:0] mem [64] = '{default: 16'h0000};
    logic        tb_oe;
    logic [15:0] tb_dq;
    logic [31:0] exp_q [$];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .writeData(writeData), .readData(readData), .ready(ready), .SRAM_DQ(SRAM_DQ),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
    );

    // SRAM model drives on reads; probe forces a known pattern to expose any controller drive
    assign tb_oe   = probe | (SRAM_WE_N & ~SRAM_OE_N);
    assign tb_dq   = probe ? 16'h5AA5 : mem[SRAM_ADDR[5:0]];
    assign SRAM_DQ = tb_oe ? tb_dq : 16'bz;

    always @(posedge clk) if (!SRAM_WE_N) mem[SRAM_ADDR[5:0]] <= SRAM_DQ;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (wr_en || rd_en) && ready) begin
            if (exp_q.size() == 0) check("scoreboard underflow", 32'd1, 32'd0);
            else check("readData", readData, exp_q.pop_front());
        end
    end

    task automatic access(input string nm, input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd, input bit drop);
        logic [31:0] off;
        int lat;
        off = a - 32'd1024;
        exp_q.push_back(exp_rd);
        wr_en = w; rd_en = r; address = a; writeData = d;
        #1 check({nm, " ready in IDLE"}, {31'd0, ready}, 32'd0);
        @(posedge clk);
        lat = 20;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check({nm, " addr lo"}, {14'd0, SRAM_ADDR}, {14'd0, off[18:2], 1'b0});
                check({nm, " we_n"}, {31'd0, SRAM_WE_N}, {31'd0, ~w});
            end
            if (i == 1) check({nm, " addr hi"}, {14'd0, SRAM_ADDR}, {14'd0, off[18:2], 1'b1});
            if (ready) begin
                lat = i;
                break;
            end
        end
        check({nm, " busy cycles"}, lat, 5);
        @(posedge clk);
        #1;
        if (drop) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        probe = 1'b1;
        #1;
        check("idle dq hi-z", {16'd0, SRAM_DQ}, 32'h5AA5);
        check("idle ready", {31'd0, ready}, 32'd1);
        check("idle we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("idle oe_n", {31'd0, SRAM_OE_N}, 32'd0);
        check("idle addr", {14'd0, SRAM_ADDR}, 32'd0);
        check("idle readData", readData, 32'd0);
        check("ce/ub/lb", {29'd0, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 32'd0);
        probe = 1'b0;
        @(posedge clk);
        #1;

        access("st0", 1, 0, 32'd1024, 32'hDEADBEEF, 32'h0, 1);
        check("mem0", {16'd0, mem[0]}, 32'hBEEF);
        check("mem1", {16'd0, mem[1]}, 32'hDEAD);
        access("ld0", 0, 1, 32'd1024, 32'h0, 32'hDEADBEEF, 1);
        access("st1", 1, 0, 32'd1036, 32'h12345678, 32'hDEADBEEF, 1);
        check("mem6", {16'd0, mem[6]}, 32'h5678);
        check("mem7", {16'd0, mem[7]}, 32'h1234);
        access("ld1", 0, 1, 32'd1037, 32'h0, 32'h12345678, 1);
        access("pri", 1, 1, 32'd1028, 32'h0BADF00D, 32'h12345678, 0);
        access("b2b", 0, 1, 32'd1028, 32'h0, 32'h0BADF00D, 1);
        check("mem2", {16'd0, mem[2]}, 32'hF00D);
        check("mem3", {16'd0, mem[3]}, 32'h0BAD);

        wr_en = 1'b1; address = 32'd1040; writeData = 32'hCAFEF00D;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        probe = 1'b1;
        #1;
        check("rst we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("rst oe_n", {31'd0, SRAM_OE_N}, 32'd0);
        check("rst addr", {14'd0, SRAM_ADDR}, 32'd0);
        check("rst readData", readData, 32'd0);
        check("rst dq hi-z", {16'd0, SRAM_DQ}, 32'h5AA5);
        check("rst ready held req", {31'd0, ready}, 32'd0);
        wr_en = 1'b0;
        probe = 1'b0;
        #1 check("rst ready no req", {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        check("mem9 not written", {16'd0, mem[9]}, 32'h0);
        check("post rst readData", readData, 32'd0);
        @(posedge clk);
        #1;
        access("ld2", 0, 1, 32'd1040, 32'h0, 32'h0000F00D, 1);

        repeat (3) @(posedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
